kbd_decoder_fifo: RTL and testbench
===================================

Name: kbd_decoder_fifo

Overview:
- Successor keyboard decoder. Consumes the raw PS/2 byte stream one strobed byte at a time.
- Parses E0/F0/E1 prefixes with an FSM and tracks Shift/Ctrl/Alt/CapsLock.
- Drives the Hack level-style key register and also queues make events in a parametrised FIFO, so the CPU can consume keystrokes without losing any.
- Sits between the PS/2 receiver and the memory-mapped keyboard register/event port.

Parameters:
- KEY_W, 16, width of oKEY and oEV_DATA (codes zero-extended from 8 bits; minimum 8).
- FIFO_DEPTH, 8, event FIFO entries (power of two, at least 2).
- CTRL_ASCII, 1, when 1, Ctrl+letter yields ASCII 1..26; when 0, Ctrl is tracked but ignored for translation.

Ports:
- iCLK  in  1  system clock.
- iRST_N  in  1  asynchronous active-low reset.
- iBYTE  in  8  received scan byte.
- iBYTE_VALID  in  1  one-cycle strobe qualifying iBYTE.
- oKEY  out  KEY_W  code of the currently held key, 0 when none.
- oEV_DATA  out  KEY_W  FIFO head: translated make code.
- oEV_VALID  out  1  FIFO non-empty.
- iEV_READY  in  1  pop head when oEV_VALID and iEV_READY are both high.
- oOVERFLOW  out  1  sticky: an event was dropped because the FIFO was full.
- oMODS  out  4  {caps, alt, ctrl, shift} live state.

Behaviour:
- Reset (async assert, sync release):
  - oKEY=0, FIFO empty, oEV_VALID=0, oOVERFLOW=0, oMODS=0.
  - FSM=IDLE, held register cleared.
- Parser FSM advances only on iBYTE_VALID. States: IDLE, EXT, BRK, EXT_BRK, SKIP.
  - IDLE: E0 goes to EXT. F0 goes to BRK. E1 goes to SKIP with cnt=7. Bytes 00/AA/FA/FE/FF are ignored. Any other byte is a make of {ext=0, byte}.
  - EXT: F0 goes to EXT_BRK. Any other byte is a make of {1, byte}, then IDLE.
  - BRK: break of {0, byte}, then IDLE. EXT_BRK: break of {1, byte}, then IDLE.
  - SKIP: discard bytes, decrement cnt, return to IDLE when cnt reaches 0. This consumes the 8-byte Pause sequence; no event and no state change.
- Modifiers (make sets, break clears; no event, no oKEY change):
  - shift = LShift 12 or RShift 59.
  - ctrl = 14 or E0 14.
  - alt = 11 or E0 11.
  - E0 12 (fake shift) is ignored.
  - Caps 58: toggles on make only if 58 is not already held, so typematic repeats do not toggle; its break clears the held flag.
- Translation (8-bit result; 0 means untranslatable and is dropped silently):
  - Same PS/2 set-2 mapping as the existing keyboard path: printable ASCII 0x20..0x7E, newline 128, backspace 129, arrows 130..133, home 134, end 135, pgup 136, pgdn 137, ins 138, del 139, esc 140, F1..F12 141..152.
  - The ext flag is ignored for translation (E0 75 and 75 both give 131; E0 5A gives 128; E0 4A gives '/').
  - Letters use shift XOR caps. All other keys use shift only.
  - With CTRL_ASCII=1 and ctrl set, a letter gives (lowercase-0x60) in the range 1..26.
- Make with nonzero code, registered on the cycle after the final byte's strobe:
  - oKEY <= code and held <= {ext, byte}.
  - Push code into the FIFO. Typematic repeats push again.
- Break:
  - oKEY <= 0 only if {ext, byte} == held; break of any other key leaves oKEY unchanged.
  - Breaks never enter the FIFO.
- FIFO:
  - oEV_VALID rises the cycle after the push.
  - Full and push without pop: drop the event and set oOVERFLOW. oOVERFLOW clears only on reset.
  - Full with simultaneous push and pop: both take effect.
  - Pop when empty is ignored.
  - Order is strict FIFO; pointers wrap modulo FIFO_DEPTH.
- Reset mid-sequence abandons any partial prefix: F0, then reset, then 1C is treated as a make.

Decomposition:
- Package kbd_pkg holds:
  - FSM state enum.
  - Prefix constants E0/F0/E1.
  - Modifier scan codes.
  - HACK key code constants 128..152.
  - Translation function taking (byte, shift_eff) and returning 8 bits.
- Sub-module kbd_event_fifo: synchronous FIFO, parameters WIDTH and DEPTH, with full/empty and async active-low reset.

Test Plan:
- 1C -> oKEY=0x0061, oEV_DATA=0x0061; then F0 1C -> oKEY=0, oEV_VALID stays 1 until popped.
- 12,1C -> oKEY=0x41; then F0 12 while A held -> oKEY stays 0x41; then F0 1C -> 0.
- 58,F0 58,1C -> 0x41; then 12,1C -> 0x61; then 12,16 -> 0x21 (caps does not affect digits); 58,58 repeat toggles caps once, oMODS[3]=1.
- E0 75 -> 131; then E0 F0 75 -> 0; E1 14 77 E1 F0 14 F0 77 -> no event, oMODS unchanged; then 1C -> 0x61.
- 14,21 -> 0x03 with CTRL_ASCII=1, 0x63 with CTRL_ASCII=0.
- FIFO_DEPTH=4, iEV_READY=0, makes 1C 32 21 23 24 -> 4 stored, oOVERFLOW=1; drain gives 61 62 63 64, then oEV_VALID=0.

Source files
------------

// File: rtl/kbd_pkg.sv
// -----------------------------------------------------------------------------
// kbd_pkg
//   Shared definitions for the PS/2 set-2 keyboard decoder:
//     - parser state enum
//     - prefix bytes (E0 extended, F0 break, E1 pause)
//     - modifier scan codes
//     - Hack special key codes (128..152)
//     - scan-code to Hack key code translation helpers
// -----------------------------------------------------------------------------
package kbd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_EXT     = 3'd1,
        ST_BRK     = 3'd2,
        ST_EXT_BRK = 3'd3,
        ST_SKIP    = 3'd4
    } kbd_state_t;

    localparam logic [7:0] PFX_E0 = 8'hE0;
    localparam logic [7:0] PFX_F0 = 8'hF0;
    localparam logic [7:0] PFX_E1 = 8'hE1;

    // Pause is E1 followed by seven more bytes that carry no key information.
    localparam logic [2:0] PAUSE_SKIP = 3'd7;

    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_CTRL   = 8'h14;
    localparam logic [7:0] SC_ALT    = 8'h11;
    localparam logic [7:0] SC_CAPS   = 8'h58;

    localparam logic [7:0] HK_NEWLINE = 8'd128;
    localparam logic [7:0] HK_BKSP    = 8'd129;
    localparam logic [7:0] HK_LEFT    = 8'd130;
    localparam logic [7:0] HK_UP      = 8'd131;
    localparam logic [7:0] HK_RIGHT   = 8'd132;
    localparam logic [7:0] HK_DOWN    = 8'd133;
    localparam logic [7:0] HK_HOME    = 8'd134;
    localparam logic [7:0] HK_END     = 8'd135;
    localparam logic [7:0] HK_PGUP    = 8'd136;
    localparam logic [7:0] HK_PGDN    = 8'd137;
    localparam logic [7:0] HK_INS     = 8'd138;
    localparam logic [7:0] HK_DEL     = 8'd139;
    localparam logic [7:0] HK_ESC     = 8'd140;
    localparam logic [7:0] HK_F1      = 8'd141;

    // Keyboard housekeeping bytes (self-test, ack, resend, error).
    function automatic logic kbd_is_filler(input logic [7:0] sc);
        return (sc == 8'h00) || (sc == 8'hAA) || (sc == 8'hFA) ||
               (sc == 8'hFE) || (sc == 8'hFF);
    endfunction

    // Lowercase ASCII for letter keys, 0 for anything else.
    function automatic logic [7:0] kbd_letter(input logic [7:0] sc);
        logic [7:0] r;
        r = 8'h00;
        case (sc)
            8'h1C: r = 8'h61;  8'h32: r = 8'h62;  8'h21: r = 8'h63;  8'h23: r = 8'h64;
            8'h24: r = 8'h65;  8'h2B: r = 8'h66;  8'h34: r = 8'h67;  8'h33: r = 8'h68;
            8'h43: r = 8'h69;  8'h3B: r = 8'h6A;  8'h42: r = 8'h6B;  8'h4B: r = 8'h6C;
            8'h3A: r = 8'h6D;  8'h31: r = 8'h6E;  8'h44: r = 8'h6F;  8'h4D: r = 8'h70;
            8'h15: r = 8'h71;  8'h2D: r = 8'h72;  8'h1B: r = 8'h73;  8'h2C: r = 8'h74;
            8'h3C: r = 8'h75;  8'h2A: r = 8'h76;  8'h1D: r = 8'h77;  8'h22: r = 8'h78;
            8'h35: r = 8'h79;  8'h1A: r = 8'h7A;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    // Non-printing keys; shift has no effect on these.
    function automatic logic [7:0] kbd_special(input logic [7:0] sc);
        logic [7:0] r;
        r = 8'h00;
        case (sc)
            8'h5A: r = HK_NEWLINE;  8'h66: r = HK_BKSP;
            8'h6B: r = HK_LEFT;     8'h75: r = HK_UP;
            8'h74: r = HK_RIGHT;    8'h72: r = HK_DOWN;
            8'h6C: r = HK_HOME;     8'h69: r = HK_END;
            8'h7D: r = HK_PGUP;     8'h7A: r = HK_PGDN;
            8'h70: r = HK_INS;      8'h71: r = HK_DEL;
            8'h76: r = HK_ESC;
            8'h05: r = HK_F1;           8'h06: r = HK_F1 + 8'd1;
            8'h04: r = HK_F1 + 8'd2;    8'h0C: r = HK_F1 + 8'd3;
            8'h03: r = HK_F1 + 8'd4;    8'h0B: r = HK_F1 + 8'd5;
            8'h83: r = HK_F1 + 8'd6;    8'h0A: r = HK_F1 + 8'd7;
            8'h01: r = HK_F1 + 8'd8;    8'h09: r = HK_F1 + 8'd9;
            8'h78: r = HK_F1 + 8'd10;   8'h07: r = HK_F1 + 8'd11;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    // Scan byte to Hack key code. shift_eff is already resolved by the caller
    // (shift XOR caps for letters, plain shift otherwise). 0 = untranslatable.
    function automatic logic [7:0] kbd_translate(input logic [7:0] sc, input logic shift_eff);
        logic [7:0] lo;
        logic [7:0] hi;
        lo = kbd_letter(sc);
        hi = lo - 8'h20;
        if (lo == 8'h00) begin
            case (sc)
                8'h45: begin lo = 8'h30; hi = 8'h29; end
                8'h16: begin lo = 8'h31; hi = 8'h21; end
                8'h1E: begin lo = 8'h32; hi = 8'h40; end
                8'h26: begin lo = 8'h33; hi = 8'h23; end
                8'h25: begin lo = 8'h34; hi = 8'h24; end
                8'h2E: begin lo = 8'h35; hi = 8'h25; end
                8'h36: begin lo = 8'h36; hi = 8'h5E; end
                8'h3D: begin lo = 8'h37; hi = 8'h26; end
                8'h3E: begin lo = 8'h38; hi = 8'h2A; end
                8'h46: begin lo = 8'h39; hi = 8'h28; end
                8'h0E: begin lo = 8'h60; hi = 8'h7E; end
                8'h4E: begin lo = 8'h2D; hi = 8'h5F; end
                8'h55: begin lo = 8'h3D; hi = 8'h2B; end
                8'h5D: begin lo = 8'h5C; hi = 8'h7C; end
                8'h54: begin lo = 8'h5B; hi = 8'h7B; end
                8'h5B: begin lo = 8'h5D; hi = 8'h7D; end
                8'h4C: begin lo = 8'h3B; hi = 8'h3A; end
                8'h52: begin lo = 8'h27; hi = 8'h22; end
                8'h41: begin lo = 8'h2C; hi = 8'h3C; end
                8'h49: begin lo = 8'h2E; hi = 8'h3E; end
                8'h4A: begin lo = 8'h2F; hi = 8'h3F; end
                8'h29: begin lo = 8'h20; hi = 8'h20; end
                default: begin lo = kbd_special(sc); hi = lo; end
            endcase
        end
        return shift_eff ? hi : lo;
    endfunction

endpackage

// File: rtl/kbd_event_fifo.sv
// -----------------------------------------------------------------------------
// kbd_event_fifo
//   Synchronous single-clock FIFO for translated key events.
//   Ports:
//     iCLK, iRST_N       clock, async active-low reset
//     iPUSH, iDATA       write request / data (ignored when full unless popping)
//     iPOP               read request (ignored when empty)
//     oDATA              head entry (meaningful only when !oEMPTY)
//     oFULL, oEMPTY      occupancy flags
//   DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module kbd_event_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic             iCLK,
    input  logic             iRST_N,
    input  logic             iPUSH,
    input  logic [WIDTH-1:0] iDATA,
    input  logic             iPOP,
    output logic [WIDTH-1:0] oDATA,
    output logic             oFULL,
    output logic             oEMPTY
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign oFULL   = (count == FULL_CNT);
    assign oEMPTY  = (count == '0);
    assign do_pop  = iPOP && !oEMPTY;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign do_push = iPUSH && (!oFULL || do_pop);
    assign oDATA   = mem[rd_ptr];

    always_ff @(posedge iCLK) begin
        if (do_push) begin
            mem[wr_ptr] <= iDATA;
        end
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/kbd_decoder_fifo.sv
// -----------------------------------------------------------------------------
// kbd_decoder_fifo
//   PS/2 set-2 scan byte decoder with modifier tracking, a level-style held
//   key register and an event FIFO of translated make codes.
//   Ports:
//     iCLK, iRST_N         clock, async active-low reset
//     iBYTE, iBYTE_VALID   scan byte and its one-cycle strobe
//     oKEY                 code of the key currently held, 0 when none
//     oEV_DATA, oEV_VALID  FIFO head and non-empty flag
//     iEV_READY            consumer ready
//     oOVERFLOW            sticky: a make event was dropped (cleared by reset)
//     oMODS                {caps, alt, ctrl, shift}
//   Event handshake: a transfer happens on every rising iCLK edge where
//   oEV_VALID and iEV_READY are both high; oEV_DATA is stable while oEV_VALID
//   is high and no transfer occurs; iEV_READY while empty has no effect.
//   The parser state register `state` is a kbd_state_t for observation.
// -----------------------------------------------------------------------------
module kbd_decoder_fifo
    import kbd_pkg::*;
#(
    parameter int KEY_W      = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int CTRL_ASCII = 1
) (
    input  logic             iCLK,
    input  logic             iRST_N,
    input  logic [7:0]       iBYTE,
    input  logic             iBYTE_VALID,
    output logic [KEY_W-1:0] oKEY,
    output logic [KEY_W-1:0] oEV_DATA,
    output logic             oEV_VALID,
    input  logic             iEV_READY,
    output logic             oOVERFLOW,
    output logic [3:0]       oMODS
);

    kbd_state_t state, state_n;
    logic [2:0] skip_cnt, skip_cnt_n;
    logic       ev_make;
    logic       ev_break;
    logic       ev_ext;

    logic       shift, ctrl, alt, caps, caps_held;
    logic [8:0] held;
    logic [8:0] key_id;
    logic       mod_key;
    logic       is_letter;
    logic       shift_eff;
    logic [7:0] code;
    logic [KEY_W-1:0] code_w;
    logic       push;
    logic       fifo_full;
    logic       fifo_empty;
    logic       overflow;

    // ---------------- prefix parser ----------------
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state    <= ST_IDLE;
            skip_cnt <= '0;
        end else begin
            state    <= state_n;
            skip_cnt <= skip_cnt_n;
        end
    end

    always_comb begin
        state_n    = state;
        skip_cnt_n = skip_cnt;
        ev_make    = 1'b0;
        ev_break   = 1'b0;
        ev_ext     = 1'b0;
        if (iBYTE_VALID) begin
            case (state)
                ST_IDLE: begin
                    if (iBYTE == PFX_E0) begin
                        state_n = ST_EXT;
                    end else if (iBYTE == PFX_F0) begin
                        state_n = ST_BRK;
                    end else if (iBYTE == PFX_E1) begin
                        state_n    = ST_SKIP;
                        skip_cnt_n = PAUSE_SKIP;
                    end else if (!kbd_is_filler(iBYTE)) begin
                        ev_make = 1'b1;
                    end
                end
                ST_EXT: begin
                    if (iBYTE == PFX_F0) begin
                        state_n = ST_EXT_BRK;
                    end else begin
                        ev_make = 1'b1;
                        ev_ext  = 1'b1;
                        state_n = ST_IDLE;
                    end
                end
                ST_BRK: begin
                    ev_break = 1'b1;
                    state_n  = ST_IDLE;
                end
                ST_EXT_BRK: begin
                    ev_break = 1'b1;
                    ev_ext   = 1'b1;
                    state_n  = ST_IDLE;
                end
                ST_SKIP: begin
                    skip_cnt_n = skip_cnt - 3'd1;
                    if (skip_cnt == 3'd1) state_n = ST_IDLE;
                end
                default: state_n = ST_IDLE;
            endcase
        end
    end

    // ---------------- translation ----------------
    assign key_id = {ev_ext, iBYTE};
    // E0 12 (fake shift) lands here too, so it is swallowed without effect.
    assign mod_key = (iBYTE == SC_LSHIFT) || (iBYTE == SC_RSHIFT) ||
                     (iBYTE == SC_CTRL)   || (iBYTE == SC_ALT)    ||
                     (iBYTE == SC_CAPS);
    assign is_letter = (kbd_letter(iBYTE) != 8'h00);
    assign shift_eff = is_letter ? (shift ^ caps) : shift;

    always_comb begin
        code = kbd_translate(iBYTE, shift_eff);
        if ((CTRL_ASCII != 0) && ctrl && is_letter) begin
            code = kbd_letter(iBYTE) - 8'h60;
        end
    end

    always_comb begin
        code_w      = '0;
        code_w[7:0] = code;
    end

    assign push = ev_make && !mod_key && (code != 8'h00);

    // ---------------- modifiers, held key, overflow ----------------
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            shift     <= 1'b0;
            ctrl      <= 1'b0;
            alt       <= 1'b0;
            caps      <= 1'b0;
            caps_held <= 1'b0;
            held      <= '0;
            oKEY      <= '0;
            overflow  <= 1'b0;
        end else begin
            if (ev_make || ev_break) begin
                if (iBYTE == SC_LSHIFT && !ev_ext) shift <= ev_make;
                if (iBYTE == SC_RSHIFT)            shift <= ev_make;
                if (iBYTE == SC_CTRL)              ctrl  <= ev_make;
                if (iBYTE == SC_ALT)               alt   <= ev_make;
                if (iBYTE == SC_CAPS) begin
                    // Typematic repeats of Caps arrive as makes while held;
                    // only the first make of a press toggles.
                    if (ev_make) begin
                        if (!caps_held) caps <= ~caps;
                        caps_held <= 1'b1;
                    end else begin
                        caps_held <= 1'b0;
                    end
                end
            end
            if (push) begin
                oKEY <= code_w;
                held <= key_id;
            end else if (ev_break && !mod_key && (key_id == held)) begin
                oKEY <= '0;
            end
            if (push && fifo_full && !iEV_READY) overflow <= 1'b1;
        end
    end

    // ---------------- event FIFO ----------------
    kbd_event_fifo #(
        .WIDTH (KEY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .iCLK   (iCLK),
        .iRST_N (iRST_N),
        .iPUSH  (push),
        .iDATA  (code_w),
        .iPOP   (iEV_READY),
        .oDATA  (oEV_DATA),
        .oFULL  (fifo_full),
        .oEMPTY (fifo_empty)
    );

    assign oEV_VALID = !fifo_empty;
    assign oOVERFLOW = overflow;
    assign oMODS     = {caps, alt, ctrl, shift};

endmodule

// File: tb/tb_kbd_decoder_fifo.sv
// -----------------------------------------------------------------------------
// tb_kbd_decoder_fifo
//   Two decoder instances share the byte stream and the ready line:
//     dut_a: FIFO_DEPTH=4, CTRL_ASCII=1
//     dut_b: FIFO_DEPTH=8, CTRL_ASCII=0
//   A reference model (prefix flags, lookup tables, expected queues) predicts
//   every output; directed scenarios add fixed expectations.
// -----------------------------------------------------------------------------
module tb_kbd_decoder_fifo;

    localparam int DEPTH_A = 4;
    localparam int DEPTH_B = 8;

    // ---------------- clock / reset / DUT ----------------
    logic        iCLK = 1'b0;
    logic        iRST_N;
    logic [7:0]  iBYTE;
    logic        iBYTE_VALID;
    logic        iEV_READY;
    logic [15:0] key_a, data_a, key_b, data_b;
    logic        valid_a, ovf_a, valid_b, ovf_b;
    logic [3:0]  mods_a, mods_b;

    always #5 iCLK = ~iCLK;

    kbd_decoder_fifo #(.KEY_W(16), .FIFO_DEPTH(DEPTH_A), .CTRL_ASCII(1)) dut_a (
        .iCLK(iCLK), .iRST_N(iRST_N), .iBYTE(iBYTE), .iBYTE_VALID(iBYTE_VALID),
        .oKEY(key_a), .oEV_DATA(data_a), .oEV_VALID(valid_a), .iEV_READY(iEV_READY),
        .oOVERFLOW(ovf_a), .oMODS(mods_a));

    kbd_decoder_fifo #(.KEY_W(16), .FIFO_DEPTH(DEPTH_B), .CTRL_ASCII(0)) dut_b (
        .iCLK(iCLK), .iRST_N(iRST_N), .iBYTE(iBYTE), .iBYTE_VALID(iBYTE_VALID),
        .oKEY(key_b), .oEV_DATA(data_b), .oEV_VALID(valid_b), .iEV_READY(iEV_READY),
        .oOVERFLOW(ovf_b), .oMODS(mods_b));

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] exp_q_a[$];
    logic [15:0] exp_q_b[$];

    logic [7:0] tbl_lo [256];
    logic [7:0] tbl_hi [256];

    logic [7:0] letter_sc [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33,
                                   8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D,
                                   8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22,
                                   8'h35, 8'h1A};
    logic [7:0] digit_sc  [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
                                   8'h3E, 8'h46};
    logic [7:0] digit_hi  [10] = '{8'h29, 8'h21, 8'h40, 8'h23, 8'h24, 8'h25, 8'h5E, 8'h26,
                                   8'h2A, 8'h28};
    // Listed in Hack code order 128..152.
    logic [7:0] spec_sc   [25] = '{8'h5A, 8'h66, 8'h6B, 8'h75, 8'h74, 8'h72, 8'h6C, 8'h69,
                                   8'h7D, 8'h7A, 8'h70, 8'h71, 8'h76, 8'h05, 8'h06, 8'h04,
                                   8'h0C, 8'h03, 8'h0B, 8'h83, 8'h0A, 8'h01, 8'h09, 8'h78,
                                   8'h07};
    logic [7:0] pool      [32] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h1A, 8'h16,
                                   8'h1E, 8'h45, 8'h29, 8'h5A, 8'h66, 8'h75, 8'h6B, 8'h74,
                                   8'h72, 8'h0E, 8'h4E, 8'h52, 8'h4A, 8'h05, 8'h07, 8'h12,
                                   8'h59, 8'h14, 8'h11, 8'h58, 8'h0D, 8'h76, 8'h71, 8'h5D};

    // model state
    bit          m_ext, m_brk;
    int          m_skip;
    bit          m_shift, m_ctrl, m_alt, m_caps, m_caps_held;
    int          m_held;
    logic [15:0] m_key_a, m_key_b;
    bit          m_ovf_a, m_ovf_b;
    bit          push_a, push_b;
    logic [7:0]  code_a, code_b;
    logic        rdy;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        check("key_a", key_a, m_key_a);
        check("key_b", key_b, m_key_b);
        check("mods_a", mods_a, {m_caps, m_alt, m_ctrl, m_shift});
        check("mods_b", mods_b, {m_caps, m_alt, m_ctrl, m_shift});
        check("valid_a", valid_a, exp_q_a.size() != 0);
        check("valid_b", valid_b, exp_q_b.size() != 0);
        if (exp_q_a.size() != 0) check("data_a", data_a, exp_q_a[0]);
        if (exp_q_b.size() != 0) check("data_b", data_b, exp_q_b[0]);
        check("ovf_a", ovf_a, m_ovf_a);
        check("ovf_b", ovf_b, m_ovf_b);
    endtask

    // ---------------- reference model ----------------
    task automatic put(input logic [7:0] sc, input logic [7:0] lo, input logic [7:0] hi);
        tbl_lo[sc] = lo;
        tbl_hi[sc] = hi;
    endtask

    task automatic init_tables();
        for (int i = 0; i < 256; i++) begin tbl_lo[i] = 8'h00; tbl_hi[i] = 8'h00; end
        for (int i = 0; i < 26; i++) put(letter_sc[i], 8'h61 + 8'(i), 8'h41 + 8'(i));
        for (int i = 0; i < 10; i++) put(digit_sc[i], 8'h30 + 8'(i), digit_hi[i]);
        for (int i = 0; i < 25; i++) put(spec_sc[i], 8'd128 + 8'(i), 8'd128 + 8'(i));
        put(8'h0E, 8'h60, 8'h7E); put(8'h4E, 8'h2D, 8'h5F); put(8'h55, 8'h3D, 8'h2B);
        put(8'h5D, 8'h5C, 8'h7C); put(8'h54, 8'h5B, 8'h7B); put(8'h5B, 8'h5D, 8'h7D);
        put(8'h4C, 8'h3B, 8'h3A); put(8'h52, 8'h27, 8'h22); put(8'h41, 8'h2C, 8'h3C);
        put(8'h49, 8'h2E, 8'h3E); put(8'h4A, 8'h2F, 8'h3F); put(8'h29, 8'h20, 8'h20);
    endtask

    task automatic model_reset();
        m_ext = 0; m_brk = 0; m_skip = 0;
        m_shift = 0; m_ctrl = 0; m_alt = 0; m_caps = 0; m_caps_held = 0;
        m_held = 0; m_key_a = '0; m_key_b = '0;
        m_ovf_a = 0; m_ovf_b = 0;
        exp_q_a.delete();
        exp_q_b.delete();
    endtask

    task automatic model_key(input bit ext, input bit brk, input logic [7:0] b);
        int         id;
        logic [7:0] lo, hi, plain;
        bit         letter, sh;
        id = ext * 256 + int'(b);
        if (b == 8'h12) begin if (!ext) m_shift = !brk; return; end
        if (b == 8'h59) begin m_shift = !brk; return; end
        if (b == 8'h14) begin m_ctrl = !brk; return; end
        if (b == 8'h11) begin m_alt = !brk; return; end
        if (b == 8'h58) begin
            if (brk) m_caps_held = 0;
            else begin
                if (!m_caps_held) m_caps = !m_caps;
                m_caps_held = 1;
            end
            return;
        end
        if (brk) begin
            if (id == m_held) begin m_key_a = '0; m_key_b = '0; end
            return;
        end
        lo = tbl_lo[b];
        hi = tbl_hi[b];
        if (lo == 8'h00) return;
        letter = (lo >= 8'h61) && (lo <= 8'h7A);
        sh     = letter ? (m_shift ^ m_caps) : m_shift;
        plain  = sh ? hi : lo;
        code_b = plain;
        code_a = (m_ctrl && letter) ? lo - 8'h60 : plain;
        m_key_a = {8'h00, code_a};
        m_key_b = {8'h00, code_b};
        m_held  = id;
        push_a  = 1;
        push_b  = 1;
    endtask

    task automatic model_byte(input logic [7:0] b);
        bit ext, brk;
        if (m_skip > 0) begin m_skip--; return; end
        if (!m_ext && !m_brk) begin
            if (b == 8'hE0) begin m_ext = 1; return; end
            if (b == 8'hF0) begin m_brk = 1; return; end
            if (b == 8'hE1) begin m_skip = 7; return; end
            if (b inside {8'h00, 8'hAA, 8'hFA, 8'hFE, 8'hFF}) return;
        end else if (m_ext && !m_brk && b == 8'hF0) begin
            m_brk = 1;
            return;
        end
        ext = m_ext;
        brk = m_brk;
        m_ext = 0;
        m_brk = 0;
        model_key(ext, brk, b);
    endtask

    // ---------------- drivers ----------------
    // One clock: check current outputs, drive inputs, advance model.
    task automatic step(input logic v, input logic [7:0] b);
        bit pop_a, pop_b;
        @(negedge iCLK);
        check_outputs();
        iBYTE_VALID = v;
        iBYTE       = b;
        iEV_READY   = rdy;
        pop_a  = rdy && (exp_q_a.size() != 0);
        pop_b  = rdy && (exp_q_b.size() != 0);
        push_a = 0;
        push_b = 0;
        if (v) model_byte(b);
        if (push_a) begin
            if (exp_q_a.size() == DEPTH_A && !pop_a) m_ovf_a = 1;
            else exp_q_a.push_back({8'h00, code_a});
        end
        if (push_b) begin
            if (exp_q_b.size() == DEPTH_B && !pop_b) m_ovf_b = 1;
            else exp_q_b.push_back({8'h00, code_b});
        end
        if (pop_a) void'(exp_q_a.pop_front());
        if (pop_b) void'(exp_q_b.pop_front());
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 8'($urandom));
    endtask

    task automatic send(input logic [7:0] b);
        step(1'b1, b);
        idle(1);
    endtask

    task automatic send_rand(input logic [7:0] b);
        step(1'b1, b);
        idle($urandom_range(0, 1));
    endtask

    task automatic do_reset();
        @(negedge iCLK);
        iRST_N      = 1'b0;
        iBYTE_VALID = 1'b0;
        iEV_READY   = 1'b0;
        model_reset();
        @(negedge iCLK);
        iRST_N = 1'b1;
    endtask

    task automatic drain();
        rdy = 1'b1;
        idle(DEPTH_B + 2);
        rdy = 1'b0;
        idle(1);
    endtask

    task automatic send_pause();
        send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
        send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic [3:0] mods_before;
        int         r;
        iRST_N = 1'b0; iBYTE = '0; iBYTE_VALID = 1'b0; iEV_READY = 1'b0; rdy = 1'b0;
        init_tables();
        model_reset();
        repeat (2) @(negedge iCLK);
        iRST_N = 1'b1;
        check("rst_key", key_a, 16'h0);
        check("rst_valid", valid_a, 1'b0);
        check("rst_ovf", ovf_a, 1'b0);
        check("rst_mods", mods_a, 4'h0);

        // plain make / break
        send(8'h1C);
        check("a_key", key_a, 16'h0061);
        check("a_data", data_a, 16'h0061);
        send(8'hF0); send(8'h1C);
        check("a_brk_key", key_a, 16'h0);
        check("a_brk_valid", valid_a, 1'b1);
        drain();
        check("a_drained", valid_a, 1'b0);

        // shift, and break of a non-held key
        send(8'h12); send(8'h1C);
        check("shift_A", key_a, 16'h0041);
        send(8'hF0); send(8'h12);
        check("other_brk", key_a, 16'h0041);
        send(8'hF0); send(8'h1C);
        check("held_brk", key_a, 16'h0);
        drain();

        // caps lock with typematic repeat
        do_reset();
        send(8'h58); send(8'h58);
        check("caps_once", mods_a, 4'b1000);
        send(8'hF0); send(8'h58); send(8'h1C);
        check("caps_A", key_a, 16'h0041);
        send(8'h12); send(8'h1C);
        check("caps_shift_a", key_a, 16'h0061);
        send(8'h16);
        check("caps_digit", key_a, 16'h0021);
        send(8'hF0); send(8'h12);
        drain();

        // extended keys and pause
        do_reset();
        send(8'hE0); send(8'h75);
        check("ext_up", key_a, 16'd131);
        send(8'hE0); send(8'hF0); send(8'h75);
        check("ext_brk", key_a, 16'h0);
        mods_before = mods_a;
        send_pause();
        check("pause_mods", mods_a, mods_before);
        check("pause_key", key_a, 16'h0);
        send(8'h1C);
        check("post_pause", key_a, 16'h0061);
        drain();

        // ctrl translation
        do_reset();
        send(8'h14); send(8'h21);
        check("ctrl_a", key_a, 16'h0003);
        check("ctrl_b", key_b, 16'h0063);
        send(8'hF0); send(8'h14);
        drain();

        // reset abandons a pending break prefix, then overflow
        send(8'hF0);
        do_reset();
        send(8'h1C);
        check("rst_prefix", key_a, 16'h0061);
        send(8'h32); send(8'h21); send(8'h23); send(8'h24);
        check("ovf_a", ovf_a, 1'b1);
        check("ovf_b", ovf_b, 1'b0);
        rdy = 1'b1;
        idle(1);
        for (int i = 0; i < 4; i++) begin
            check("drain_a", data_a, 16'h0061 + 16'(i));
            idle(1);
        end
        check("drain_empty", valid_a, 1'b0);
        rdy = 1'b0;
        drain();

        // full FIFO with simultaneous push and pop
        send(8'h1C); send(8'h32); send(8'h21); send(8'h23);
        rdy = 1'b1;
        step(1'b1, 8'h2B);
        rdy = 1'b0;
        idle(2);
        drain();

        // randomized traffic
        for (int n = 0; n < 500; n++) begin
            r   = $urandom_range(0, 19);
            rdy = (n < 250) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            if (r == 0) begin
                send_pause();
            end else if (r == 1) begin
                case ($urandom_range(0, 4))
                    0: send_rand(8'h00);
                    1: send_rand(8'hAA);
                    2: send_rand(8'hFA);
                    3: send_rand(8'hFE);
                    default: send_rand(8'hFF);
                endcase
            end else if (r == 2 && $urandom_range(0, 3) == 0) begin
                do_reset();
            end else begin
                if ($urandom_range(0, 3) == 0) send_rand(8'hE0);
                if ($urandom_range(0, 2) == 0) send_rand(8'hF0);
                send_rand(pool[$urandom_range(0, 31)]);
            end
        end
        rdy = 1'b1;
        idle(DEPTH_B + 2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
